// File: rtl/ysyx_22040759_exmem_buf_pkg.sv
// rtl/ysyx_22040759_exmem_buf_pkg.sv - EX/MEM buffer state encodings, entry layout and packing helper
package ysyx_22040759_exmem_buf_pkg;

    localparam int EXMEM_DATA_W  = 64;
    localparam int EXMEM_ENTRY_W = 3*EXMEM_DATA_W + 5 + 1 + 1 + 1 + 3;

    // Entry layout, LSB first: size, mem_wr, mem_rd, wb_en, rd, pc, store_data, alu_result
    localparam int EXMEM_OFF_SIZE   = 0;
    localparam int EXMEM_OFF_MEM_WR = 3;
    localparam int EXMEM_OFF_MEM_RD = 4;
    localparam int EXMEM_OFF_WB_EN  = 5;
    localparam int EXMEM_OFF_RD     = 6;
    localparam int EXMEM_OFF_PC     = 11;
    localparam int EXMEM_OFF_STORE  = EXMEM_OFF_PC + EXMEM_DATA_W;
    localparam int EXMEM_OFF_ALU    = EXMEM_OFF_STORE + EXMEM_DATA_W;

    typedef enum logic [1:0] {
        EXMEM_EMPTY = 2'd0,
        EXMEM_ONE   = 2'd1,
        EXMEM_TWO   = 2'd2
    } exmem_state_e;

    function automatic logic [EXMEM_ENTRY_W-1:0] exmem_pack(
        input logic [EXMEM_DATA_W-1:0] alu_result,
        input logic [EXMEM_DATA_W-1:0] store_data,
        input logic [EXMEM_DATA_W-1:0] pc,
        input logic [4:0]              rd,
        input logic                    wb_en,
        input logic                    mem_rd,
        input logic                    mem_wr,
        input logic [2:0]              mem_size
    );
        return {alu_result, store_data, pc, rd, wb_en, mem_rd, mem_wr, mem_size};
    endfunction

endpackage

// File: rtl/ysyx_22040759_exmem_slot.sv
// rtl/ysyx_22040759_exmem_slot.sv - entry-wide register with load enable and async active-low clear
module ysyx_22040759_exmem_slot #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_load,
    input  logic [W-1:0] i_d,
    output logic [W-1:0] o_q
);

    logic [W-1:0] r_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q <= '0;
        end else if (i_load) begin
            r_q <= i_d;
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/ysyx_22040759_exmem_buf.sv
// rtl/ysyx_22040759_exmem_buf.sv - EX/MEM two-entry skid buffer with head forwarding
// Optional forwarding enabled by defining YSYX_22040759_EXMEM_FWD_EN.
module ysyx_22040759_exmem_buf
    import ysyx_22040759_exmem_buf_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    flush,
    input  logic                    ex_valid,
    output logic                    ex_ready,
    input  logic [EXMEM_DATA_W-1:0] ex_alu_result,
    input  logic [EXMEM_DATA_W-1:0] ex_store_data,
    input  logic [EXMEM_DATA_W-1:0] ex_pc,
    input  logic [4:0]              ex_rd,
    input  logic                    ex_wb_en,
    input  logic                    ex_mem_rd,
    input  logic                    ex_mem_wr,
    input  logic [2:0]              ex_mem_size,
    output logic                    mem_valid,
    input  logic                    mem_ready,
    output logic [EXMEM_DATA_W-1:0] mem_alu_result,
    output logic [EXMEM_DATA_W-1:0] mem_store_data,
    output logic [EXMEM_DATA_W-1:0] mem_pc,
    output logic [4:0]              mem_rd,
    output logic                    mem_wb_en,
    output logic                    mem_mem_rd,
    output logic                    mem_mem_wr,
    output logic [2:0]              mem_mem_size,
    output logic                    fwd_valid,
    output logic [4:0]              fwd_rd,
    output logic [EXMEM_DATA_W-1:0] fwd_data
);

    exmem_state_e r_state;
    exmem_state_e w_next;

    logic                     w_push;
    logic                     w_pop;
    logic                     w_head_load;
    logic                     w_skid_load;
    logic [EXMEM_ENTRY_W-1:0] w_in;
    logic [EXMEM_ENTRY_W-1:0] w_head_d;
    logic [EXMEM_ENTRY_W-1:0] w_head_q;
    logic [EXMEM_ENTRY_W-1:0] w_skid_q;

    // Handshake flags depend only on registered state
    assign ex_ready  = (r_state != EXMEM_TWO);
    assign mem_valid = (r_state != EXMEM_EMPTY);
    assign w_push    = ex_valid & ex_ready;
    assign w_pop     = mem_valid & mem_ready;

    assign w_in = exmem_pack(ex_alu_result, ex_store_data, ex_pc, ex_rd,
                             ex_wb_en, ex_mem_rd, ex_mem_wr, ex_mem_size);
    assign w_head_d = (r_state == EXMEM_TWO) ? w_skid_q : w_in;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= EXMEM_EMPTY;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next      = r_state;
        w_head_load = 1'b0;
        w_skid_load = 1'b0;
        case (r_state)
            EXMEM_EMPTY: begin
                if (w_push) begin
                    w_next      = EXMEM_ONE;
                    w_head_load = 1'b1;
                end
            end
            EXMEM_ONE: begin
                if (w_push && w_pop) begin
                    w_head_load = 1'b1;
                end else if (w_push) begin
                    w_next      = EXMEM_TWO;
                    w_skid_load = 1'b1;
                end else if (w_pop) begin
                    w_next      = EXMEM_EMPTY;
                end
            end
            EXMEM_TWO: begin
                if (w_pop) begin
                    w_next      = EXMEM_ONE;
                    w_head_load = 1'b1;
                end
            end
            default: w_next = EXMEM_EMPTY;
        endcase
        // Flush drops any same-cycle push; a pop has already been seen by MEM
        if (flush) begin
            w_next      = EXMEM_EMPTY;
            w_head_load = 1'b0;
            w_skid_load = 1'b0;
        end
    end

    ysyx_22040759_exmem_slot #(.W(EXMEM_ENTRY_W)) u_head (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_load (w_head_load),
        .i_d    (w_head_d),
        .o_q    (w_head_q)
    );

    ysyx_22040759_exmem_slot #(.W(EXMEM_ENTRY_W)) u_skid (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_load (w_skid_load),
        .i_d    (w_in),
        .o_q    (w_skid_q)
    );

    assign mem_alu_result = w_head_q[EXMEM_OFF_ALU   +: EXMEM_DATA_W];
    assign mem_store_data = w_head_q[EXMEM_OFF_STORE +: EXMEM_DATA_W];
    assign mem_pc         = w_head_q[EXMEM_OFF_PC    +: EXMEM_DATA_W];
    assign mem_rd         = w_head_q[EXMEM_OFF_RD    +: 5];
    assign mem_wb_en      = w_head_q[EXMEM_OFF_WB_EN];
    assign mem_mem_rd     = w_head_q[EXMEM_OFF_MEM_RD];
    assign mem_mem_wr     = w_head_q[EXMEM_OFF_MEM_WR];
    assign mem_mem_size   = w_head_q[EXMEM_OFF_SIZE  +: 3];

`ifdef YSYX_22040759_EXMEM_FWD_EN
    // Loads are not forwarded: their data only exists after MEM
    assign fwd_valid = mem_valid & mem_wb_en & ~mem_mem_rd & (mem_rd != 5'd0);
    assign fwd_rd    = mem_rd;
    assign fwd_data  = mem_alu_result;
`else
    assign fwd_valid = 1'b0;
    assign fwd_rd    = 5'd0;
    assign fwd_data  = '0;
`endif

    a_no_rd_and_wr: assert property (@(posedge clk) disable iff (!rst_n)
        w_push |-> !(ex_mem_rd && ex_mem_wr));

endmodule
